m68k_waitstate_gen: RTL and testbench

- Bus-cycle timing stage directly downstream of the m68kdecoder address decoder.
- Consumes the decoder's chip selects and the CPU address strobe.
- Produces the dtack_trig request that the decoder turns into DTACK_n, with per-device programmable wait states and external-ready handshake on device 3.
- Produces a bus-error request when no device answers within a timeout. All logic runs on clk50.

---
 rtl/m68k_waitstate_gen.sv | 150 +++++++++++++++
 tb/tb_m68k_waitstate_gen.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/m68k_waitstate_gen.sv
// Bus-cycle timing stage behind the m68k address decoder: per-device wait states,
// external-ready handshake on device 3 and bus-error timeout, all on clk50.
module m68k_waitstate_gen #(
  parameter int WAIT0     = 0,
  parameter int WAIT1     = 1,
  parameter int WAIT2     = 4,
  parameter int TIMEOUT   = 200,
  parameter int DTACK_LEN = 2,
  parameter int CW        = 8
) (
  input  logic       clk50,
  input  logic       reset,
  input  logic       as_n,
  input  logic [3:0] cs,
  input  logic       ext_ready,
  output logic       dtack_trig,
  output logic       berr_req,
  output logic       busy
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_EXT,
    ST_NOSEL,
    ST_ACK,
    ST_BERR,
    ST_HOLD
  } state_t;

  localparam logic [CW-1:0] ACK_LOAD = CW'(DTACK_LEN - 1);

  state_t        state, state_nx;
  logic [CW-1:0] wcnt, wcnt_nx;
  logic [CW-1:0] tcnt, tcnt_nx;
  logic          dtack_nx, berr_nx;
  logic          as_meta, as_s;
  logic          rdy_meta, rdy_s;

  // NOTE: state and synchronizer flops use non-blocking assignments so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk50) begin
    if (reset) begin
      state      <= ST_IDLE;
      wcnt       <= '0;
      tcnt       <= '0;
      dtack_trig <= 1'b0;
      berr_req   <= 1'b0;
      as_meta    <= 1'b1;
      as_s       <= 1'b1;
      rdy_meta   <= 1'b0;
      rdy_s      <= 1'b0;
    end else begin
      state      <= state_nx;
      wcnt       <= wcnt_nx;
      tcnt       <= tcnt_nx;
      dtack_trig <= dtack_nx;
      berr_req   <= berr_nx;
      as_meta    <= as_n;
      as_s       <= as_meta;
      rdy_meta   <= ext_ready;
      rdy_s      <= rdy_meta;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nx = state;
    wcnt_nx  = wcnt;
    tcnt_nx  = tcnt;
    dtack_nx = 1'b0;
    berr_nx  = 1'b0;

    // Strobe released: abandon the cycle immediately, even mid-ACK.
    if (state != ST_IDLE && as_s) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!as_s) begin
            tcnt_nx = CW'(TIMEOUT);
            if (cs[0]) begin
              state_nx = ST_WAIT;
              wcnt_nx  = CW'(WAIT0);
            end else if (cs[1]) begin
              state_nx = ST_WAIT;
              wcnt_nx  = CW'(WAIT1);
            end else if (cs[2]) begin
              state_nx = ST_WAIT;
              wcnt_nx  = CW'(WAIT2);
            end else if (cs[3]) begin
              state_nx = ST_EXT;
            end else begin
              state_nx = ST_NOSEL;
            end
          end
        end
        ST_WAIT: begin
          if (wcnt == '0) begin
            state_nx = ST_ACK;
            wcnt_nx  = ACK_LOAD;
            dtack_nx = 1'b1;
          end else if (tcnt == '0) begin
            state_nx = ST_BERR;
            berr_nx  = 1'b1;
          end else begin
            wcnt_nx = wcnt - CW'(1);
            tcnt_nx = tcnt - CW'(1);
          end
        end
        ST_EXT: begin
          if (rdy_s) begin
            state_nx = ST_ACK;
            wcnt_nx  = ACK_LOAD;
            dtack_nx = 1'b1;
          end else if (tcnt == '0) begin
            state_nx = ST_BERR;
            berr_nx  = 1'b1;
          end else begin
            tcnt_nx = tcnt - CW'(1);
          end
        end
        ST_NOSEL: begin
          if (tcnt == '0) begin
            state_nx = ST_BERR;
            berr_nx  = 1'b1;
          end else begin
            tcnt_nx = tcnt - CW'(1);
          end
        end
        // wcnt is reused as the remaining-pulse counter while acknowledging.
        ST_ACK: begin
          if (wcnt == '0) begin
            state_nx = ST_HOLD;
          end else begin
            wcnt_nx  = wcnt - CW'(1);
            dtack_nx = 1'b1;
          end
        end
        ST_BERR: berr_nx = 1'b1;
        ST_HOLD: ;
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_m68k_waitstate_gen.sv
// Directed bench for m68k_waitstate_gen; edge numbers are counted from the
// negedge where as_n falls, so the detect edge D is edge 3.
module tb_m68k_waitstate_gen;

  logic       clk50;
  logic       reset;
  logic       as_n;
  logic [3:0] cs;
  logic       ext_ready;
  logic       dtack_trig;
  logic       berr_req;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  int   ec;
  int   dt_cnt, be_cnt, both_cnt;
  logic dt_h [0:255];
  logic be_h [0:255];
  logic bz_h [0:255];

  m68k_waitstate_gen dut (
    .clk50     (clk50),
    .reset     (reset),
    .as_n      (as_n),
    .cs        (cs),
    .ext_ready (ext_ready),
    .dtack_trig(dtack_trig),
    .berr_req  (berr_req),
    .busy      (busy)
  );

  initial clk50 = 1'b0;
  always #10 clk50 = ~clk50;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One clk50 edge, sampled on the following negedge and logged by edge number.
  task automatic step();
    @(posedge clk50);
    @(negedge clk50);
    ec++;
    if (ec < 256) begin
      dt_h[ec] = dtack_trig;
      be_h[ec] = berr_req;
      bz_h[ec] = busy;
    end
    if (dtack_trig) dt_cnt++;
    if (berr_req) be_cnt++;
    if (dtack_trig && berr_req) both_cnt++;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic start(input logic [3:0] c);
    cs     = c;
    as_n   = 1'b0;
    ec     = 0;
    dt_cnt = 0;
    be_cnt = 0;
  endtask

  task automatic finish_cycle(input string tag);
    as_n = 1'b1;
    steps(3);
    check(tag, int'(busy), 0);
  endtask

  initial begin
    reset     = 1'b1;
    as_n      = 1'b1;
    cs        = 4'b0000;
    ext_ready = 1'b0;
    both_cnt  = 0;
    ec        = 0;
    repeat (2) @(negedge clk50);
    check("rst_dtack", int'(dtack_trig), 0);
    check("rst_berr", int'(berr_req), 0);
    check("rst_busy", int'(busy), 0);
    reset = 1'b0;
    steps(2);

    // Back-to-back: device 0 (no waits) then device 2 (4 waits)
    start(4'b0001);
    steps(8);
    check("b2b0_busy_d", int'(bz_h[3]), 1);
    check("b2b0_dt_d", int'(dt_h[3]), 0);
    check("b2b0_dt_d1", int'(dt_h[4]), 1);
    check("b2b0_dt_d2", int'(dt_h[5]), 1);
    check("b2b0_dt_d3", int'(dt_h[6]), 0);
    check("b2b0_dt_cnt", dt_cnt, 2);
    as_n = 1'b1;
    steps(3);
    check("b2b0_busy_hold", int'(bz_h[10]), 1);
    check("b2b0_busy_idle", int'(bz_h[11]), 0);
    start(4'b0100);
    steps(12);
    check("b2b2_dt_d4", int'(dt_h[7]), 0);
    check("b2b2_dt_d5", int'(dt_h[8]), 1);
    check("b2b2_dt_d6", int'(dt_h[9]), 1);
    check("b2b2_dt_d7", int'(dt_h[10]), 0);
    check("b2b2_dt_cnt", dt_cnt, 2);
    check("b2b2_berr_cnt", be_cnt, 0);
    finish_cycle("b2b2_end_busy");

    // External ready raised 10 cycles after D
    start(4'b1000);
    steps(13);
    ext_ready = 1'b1;
    steps(6);
    check("ext_dt_r2", int'(dt_h[15]), 0);
    check("ext_dt_r3", int'(dt_h[16]), 1);
    check("ext_dt_r4", int'(dt_h[17]), 1);
    check("ext_dt_r5", int'(dt_h[18]), 0);
    check("ext_dt_cnt", dt_cnt, 2);
    ext_ready = 1'b0;
    finish_cycle("ext_end_busy");

    // Unmapped address: bus error after the timeout
    start(4'b0000);
    steps(205);
    check("nosel_be_d200", int'(be_h[203]), 0);
    check("nosel_be_d201", int'(be_h[204]), 1);
    check("nosel_be_d202", int'(be_h[205]), 1);
    check("nosel_dt_cnt", dt_cnt, 0);
    as_n = 1'b1;
    steps(3);
    check("nosel_be_held", int'(be_h[207]), 1);
    check("nosel_be_drop", int'(be_h[208]), 0);
    check("nosel_busy_idle", int'(bz_h[208]), 0);

    // Device 3 never ready: timeout, late ready ignored
    start(4'b1000);
    steps(204);
    check("extto_be_d200", int'(be_h[203]), 0);
    check("extto_be_d201", int'(be_h[204]), 1);
    ext_ready = 1'b1;
    steps(4);
    ext_ready = 1'b0;
    steps(2);
    check("extto_be_late", int'(be_h[210]), 1);
    check("extto_dt_cnt", dt_cnt, 0);
    finish_cycle("extto_end_busy");

    // Abort: strobe released 2 cycles after D on a 4-wait device
    start(4'b0100);
    steps(5);
    as_n = 1'b1;
    steps(5);
    check("abort_busy_r2", int'(bz_h[7]), 1);
    check("abort_busy_r3", int'(bz_h[8]), 0);
    check("abort_dt_cnt", dt_cnt, 0);
    check("abort_be_cnt", be_cnt, 0);

    // Reset during the ACK pulse, then a normal cycle
    start(4'b0001);
    steps(4);
    check("rstmid_dt_pre", int'(dt_h[4]), 1);
    reset = 1'b1;
    step();
    check("rstmid_dt", int'(dtack_trig), 0);
    check("rstmid_busy", int'(busy), 0);
    reset = 1'b0;
    start(4'b0001);
    steps(7);
    check("rstmid_re_dt_d", int'(dt_h[3]), 0);
    check("rstmid_re_dt_d1", int'(dt_h[4]), 1);
    check("rstmid_re_dt_d2", int'(dt_h[5]), 1);
    check("rstmid_re_dt_d3", int'(dt_h[6]), 0);
    finish_cycle("rstmid_end_busy");

    // Priority: cs[1] beats cs[2]
    start(4'b0110);
    steps(8);
    check("prio_dt_d1", int'(dt_h[4]), 0);
    check("prio_dt_d2", int'(dt_h[5]), 1);
    check("prio_dt_d3", int'(dt_h[6]), 1);
    check("prio_dt_d4", int'(dt_h[7]), 0);
    finish_cycle("prio_end_busy");

    check("never_both", both_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
